// File: rtl/pipelined_control_unit_pkg.sv
// Shared types and constants for the pipelined RV32I control and hazard unit.
package control_pkg;

    // Control bundle carried from Decode down to Writeback.
    typedef struct packed {
        logic       valid;
        logic [1:0] branch;
        logic [2:0] imm_src;
        logic       alu_src;
        logic [1:0] result_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // RV32I major opcodes understood by the decoder.
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // Operand forwarding selects for the Execute-stage ALU inputs.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Builds a valid bundle with arguments in decode-table column order.
    function automatic ctrl_t mk_ctrl(
        input logic [1:0] alu_op,
        input logic       alu_src,
        input logic [1:0] result_src,
        input logic       reg_write,
        input logic       mem_write,
        input logic [2:0] imm_src,
        input logic [1:0] branch,
        input logic       mem_read
    );
        ctrl_t c;
        c.valid      = 1'b1;
        c.branch     = branch;
        c.imm_src    = imm_src;
        c.alu_src    = alu_src;
        c.result_src = result_src;
        c.reg_write  = reg_write;
        c.mem_write  = mem_write;
        c.mem_read   = mem_read;
        c.alu_op     = alu_op;
        return c;
    endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Bundle between the datapath (master) and the control/hazard unit (slave).
interface pipelined_control_unit_if #(
    parameter int REG_AW = 5
);
    import control_pkg::*;

    logic [31:0]       instr_d;
    logic              pc_src_e;
    logic              hold;
    ctrl_t             ctrl_d;
    ctrl_t             ctrl_e;
    ctrl_t             ctrl_m;
    ctrl_t             ctrl_w;
    logic [REG_AW-1:0] rd_e;
    logic [REG_AW-1:0] rd_m;
    logic [REG_AW-1:0] rd_w;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic [1:0]        forward_a_e;
    logic [1:0]        forward_b_e;
    logic              illegal_d;

    modport master (
        output instr_d, pc_src_e, hold,
        input  ctrl_d, ctrl_e, ctrl_m, ctrl_w, rd_e, rd_m, rd_w,
               stall_f, stall_d, flush_d, forward_a_e, forward_b_e, illegal_d
    );

    modport slave (
        input  instr_d, pc_src_e, hold,
        output ctrl_d, ctrl_e, ctrl_m, ctrl_w, rd_e, rd_m, rd_w,
               stall_f, stall_d, flush_d, forward_a_e, forward_b_e, illegal_d
    );
endinterface

// File: rtl/pipelined_control_unit_decode.sv
// Main decoder: opcode -> control bundle, illegal flag and source-use flags.
module control_decode
    import control_pkg::*;
(
    input  logic [6:0] i_opcode,
    output ctrl_t      o_ctrl,
    output logic       o_illegal,
    output logic       o_use_rs1,
    output logic       o_use_rs2
);

    // Table lookup; unknown opcodes fall through to an all-zero bundle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        o_ctrl    = CTRL_BUBBLE;
        o_illegal = 1'b0;
        o_use_rs1 = 1'b0;
        o_use_rs2 = 1'b0;
        case (i_opcode)
            OP_R: begin
                o_ctrl    = mk_ctrl(2'b10, 1'b0, 2'b01, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0);
                o_use_rs1 = 1'b1;
                o_use_rs2 = 1'b1;
            end
            OP_B: begin
                o_ctrl    = mk_ctrl(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 2'b01, 1'b0);
                o_use_rs1 = 1'b1;
                o_use_rs2 = 1'b1;
            end
            OP_I: begin
                o_ctrl    = mk_ctrl(2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0);
                o_use_rs1 = 1'b1;
            end
            OP_LOAD: begin
                o_ctrl    = mk_ctrl(2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 3'b000, 2'b00, 1'b1);
                o_use_rs1 = 1'b1;
            end
            OP_STORE: begin
                o_ctrl    = mk_ctrl(2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 3'b001, 2'b00, 1'b0);
                o_use_rs1 = 1'b1;
                o_use_rs2 = 1'b1;
            end
            OP_JAL: begin
                o_ctrl    = mk_ctrl(2'b11, 1'b1, 2'b10, 1'b1, 1'b0, 3'b011, 2'b10, 1'b0);
            end
            OP_LUI: begin
                o_ctrl    = mk_ctrl(2'b00, 1'b0, 2'b11, 1'b1, 1'b0, 3'b100, 2'b00, 1'b0);
            end
            OP_JALR: begin
                o_ctrl    = mk_ctrl(2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 3'b000, 2'b11, 1'b0);
                o_use_rs1 = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Control and hazard unit: stage bundles, stall/flush generation, forwarding.
module pipelined_control_unit
    import control_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter bit FWD_EN  = 1'b1,
    parameter bit HOLD_EN = 1'b1
) (
    input logic                     clk,
    input logic                     rst,
    pipelined_control_unit_if.slave bus
);

    ctrl_t             w_ctrl_d;
    logic              w_illegal_d;
    logic              w_use_rs1_d;
    logic              w_use_rs2_d;
    logic [REG_AW-1:0] w_rs1_d;
    logic [REG_AW-1:0] w_rs2_d;
    logic [REG_AW-1:0] w_rd_d;

    ctrl_t             r_ctrl_e;
    ctrl_t             r_ctrl_m;
    ctrl_t             r_ctrl_w;
    logic [REG_AW-1:0] r_rd_e;
    logic [REG_AW-1:0] r_rd_m;
    logic [REG_AW-1:0] r_rd_w;
    logic [REG_AW-1:0] r_rs1_e;
    logic [REG_AW-1:0] r_rs2_e;

    logic w_hit_e;
    logic w_hit_m;
    logic w_load_use;
    logic w_raw_stall;
    logic w_hazard;
    logic w_hold;
    logic w_bubble_e;
    logic w_unused;

    // Register fields resized to the configured address width.
    assign w_rs1_d = REG_AW'(bus.instr_d[19:15]);
    assign w_rs2_d = REG_AW'(bus.instr_d[24:20]);
    assign w_rd_d  = REG_AW'(bus.instr_d[11:7]);

    // funct3/funct7 belong to the ALU decoder, not to this unit.
    assign w_unused = ^{bus.instr_d[31:25], bus.instr_d[14:12]};

    control_decode u_decode (
        .i_opcode  (bus.instr_d[6:0]),
        .o_ctrl    (w_ctrl_d),
        .o_illegal (w_illegal_d),
        .o_use_rs1 (w_use_rs1_d),
        .o_use_rs2 (w_use_rs2_d)
    );

    // A used, non-x0 source that names the given destination.
    function automatic logic src_hit(
        input logic              use_f,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd
    );
        return use_f && (rs != '0) && (rs == rd);
    endfunction

    // Forward select for one Execute source; MEM beats WB, x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] rd_w
    );
        if (rs == '0)               return FWD_RF;
        if (wr_m && (rd_m == rs))   return FWD_MEM;
        if (wr_w && (rd_w == rs))   return FWD_WB;
        return FWD_RF;
    endfunction

    assign w_hit_e = src_hit(w_use_rs1_d, w_rs1_d, r_rd_e) | src_hit(w_use_rs2_d, w_rs2_d, r_rd_e);
    assign w_hit_m = src_hit(w_use_rs1_d, w_rs1_d, r_rd_m) | src_hit(w_use_rs2_d, w_rs2_d, r_rd_m);

    // A load in Execute cannot forward its data in time, whatever the mode.
    assign w_load_use = r_ctrl_e.valid & r_ctrl_e.mem_read & w_hit_e;

    // Without forwarding, any in-flight writer in E or M blocks the consumer.
    assign w_raw_stall = FWD_EN ? 1'b0
                       : ((r_ctrl_e.valid & r_ctrl_e.reg_write & w_hit_e) |
                          (r_ctrl_m.valid & r_ctrl_m.reg_write & w_hit_m));

    assign w_hazard   = w_load_use | w_raw_stall;
    assign w_hold     = HOLD_EN ? bus.hold : 1'b0;
    assign w_bubble_e = w_hazard | bus.pc_src_e;

    // Hold freezes everything; a taken branch overrides a hazard stall.
    assign bus.stall_f = w_hold | (w_hazard & ~bus.pc_src_e);
    assign bus.stall_d = bus.stall_f;
    assign bus.flush_d = ~w_hold & bus.pc_src_e;

    assign bus.forward_a_e = FWD_EN ? fwd_sel(r_rs1_e, r_ctrl_m.reg_write, r_rd_m,
                                              r_ctrl_w.reg_write, r_rd_w) : FWD_RF;
    assign bus.forward_b_e = FWD_EN ? fwd_sel(r_rs2_e, r_ctrl_m.reg_write, r_rd_m,
                                              r_ctrl_w.reg_write, r_rd_w) : FWD_RF;

    // ID/EX, EX/MEM and MEM/WB stage registers.
    always_ff @(posedge clk) begin
        // NOTE: stage state uses non-blocking assignments so every stage samples the pre-edge value of the one before.
        if (rst) begin
            r_ctrl_e <= CTRL_BUBBLE;
            r_ctrl_m <= CTRL_BUBBLE;
            r_ctrl_w <= CTRL_BUBBLE;
            r_rd_e   <= '0;
            r_rd_m   <= '0;
            r_rd_w   <= '0;
            r_rs1_e  <= '0;
            r_rs2_e  <= '0;
        end else if (!w_hold) begin
            if (w_bubble_e) begin
                r_ctrl_e <= CTRL_BUBBLE;
                r_rd_e   <= '0;
                r_rs1_e  <= '0;
                r_rs2_e  <= '0;
            end else begin
                r_ctrl_e <= w_ctrl_d;
                r_rd_e   <= w_rd_d;
                r_rs1_e  <= w_rs1_d;
                r_rs2_e  <= w_rs2_d;
            end
            r_ctrl_m <= r_ctrl_e;
            r_rd_m   <= r_rd_e;
            r_ctrl_w <= r_ctrl_m;
            r_rd_w   <= r_rd_m;
        end
    end

    assign bus.ctrl_d    = w_ctrl_d;
    assign bus.illegal_d = w_illegal_d;
    assign bus.ctrl_e    = r_ctrl_e;
    assign bus.ctrl_m    = r_ctrl_m;
    assign bus.ctrl_w    = r_ctrl_w;
    assign bus.rd_e      = r_rd_e;
    assign bus.rd_m      = r_rd_m;
    assign bus.rd_w      = r_rd_w;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench: a forwarding unit and a stall-only unit share one directed stimulus
// stream; a stage-array model predicts both every cycle, literals pin the model.
module tb_pipelined_control_unit;
    import control_pkg::*;

    // Opcodes restated locally so a wrong package constant is visible.
    localparam logic [6:0] T_R     = 7'b0110011;
    localparam logic [6:0] T_B     = 7'b1100011;
    localparam logic [6:0] T_I     = 7'b0010011;
    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_JAL   = 7'b1101111;
    localparam logic [6:0] T_LUI   = 7'b0110111;
    localparam logic [6:0] T_JALR  = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        pc_src;
    logic        hold;
    logic        chk_en;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    pipelined_control_unit_if #(.REG_AW(5)) bus0 ();
    pipelined_control_unit_if #(.REG_AW(5)) bus1 ();

    assign bus0.instr_d  = instr;
    assign bus0.pc_src_e = pc_src;
    assign bus0.hold     = hold;
    assign bus1.instr_d  = instr;
    assign bus1.pc_src_e = pc_src;
    assign bus1.hold     = hold;

    pipelined_control_unit #(.REG_AW(5), .FWD_EN(1'b1), .HOLD_EN(1'b1)) u_fwd (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    pipelined_control_unit #(.REG_AW(5), .FWD_EN(1'b0), .HOLD_EN(1'b1)) u_stall (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- model: per unit, slots 0=E 1=M 2=W ----------------
    typedef struct packed {
        ctrl_t      c;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } slot_t;

    slot_t ms [2][3];

    function automatic bit fwd_on(input int k);
        return (k == 0);
    endfunction

    function automatic ctrl_t ref_decode(input logic [6:0] op);
        ctrl_t c = '0;
        c.valid = 1'b1;
        case (op)
            T_R:     begin c.alu_op = 2'b10; c.result_src = 2'b01; c.reg_write = 1'b1; end
            T_B:     begin c.alu_op = 2'b01; c.imm_src = 3'b010; c.branch = 2'b01; end
            T_I:     begin c.alu_src = 1'b1; c.result_src = 2'b01; c.reg_write = 1'b1; end
            T_LOAD:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1; end
            T_STORE: begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.imm_src = 3'b001; end
            T_JAL:   begin c.alu_op = 2'b11; c.alu_src = 1'b1; c.result_src = 2'b10;
                           c.reg_write = 1'b1; c.imm_src = 3'b011; c.branch = 2'b10; end
            T_LUI:   begin c.result_src = 2'b11; c.reg_write = 1'b1; c.imm_src = 3'b100; end
            T_JALR:  begin c.result_src = 2'b10; c.reg_write = 1'b1; c.branch = 2'b11; end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Does Decode have to wait on register s in unit k?
    function automatic bit waits_on(input int k, input logic [4:0] s);
        if (s == 5'd0) return 1'b0;
        if (ms[k][0].c.mem_read && ms[k][0].rd == s) return 1'b1;
        if (!fwd_on(k)) begin
            if (ms[k][0].c.reg_write && ms[k][0].rd == s) return 1'b1;
            if (ms[k][1].c.reg_write && ms[k][1].rd == s) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit ref_hazard(input int k);
        logic [6:0] op = instr[6:0];
        bit r1 = 1'b0;
        bit r2 = 1'b0;
        if (op inside {T_R, T_B, T_I, T_LOAD, T_STORE, T_JALR}) r1 = waits_on(k, instr[19:15]);
        if (op inside {T_R, T_B, T_STORE})                      r2 = waits_on(k, instr[24:20]);
        return r1 || r2;
    endfunction

    function automatic logic [1:0] ref_fwd(input int k, input logic [4:0] s);
        if (!fwd_on(k) || s == 5'd0) return 2'b00;
        if (ms[k][1].c.reg_write && ms[k][1].rd == s) return 2'b10;
        if (ms[k][2].c.reg_write && ms[k][2].rd == s) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_dut(
        input int k, input ctrl_t cd, input ctrl_t ce, input ctrl_t cm, input ctrl_t cw,
        input logic [4:0] re, input logic [4:0] rm, input logic [4:0] rw,
        input logic sf, input logic sd, input logic fd,
        input logic [1:0] fa, input logic [1:0] fb, input logic il
    );
        ctrl_t exp_cd = ref_decode(instr[6:0]);
        logic  hz     = ref_hazard(k);
        logic  exp_sf = hold | (hz & ~pc_src);
        check($sformatf("u%0d ctrl_d", k), 32'(cd), 32'(exp_cd));
        check($sformatf("u%0d illegal_d", k), 32'(il), 32'(!exp_cd.valid));
        check($sformatf("u%0d ctrl_e", k), 32'(ce), 32'(ms[k][0].c));
        check($sformatf("u%0d ctrl_m", k), 32'(cm), 32'(ms[k][1].c));
        check($sformatf("u%0d ctrl_w", k), 32'(cw), 32'(ms[k][2].c));
        check($sformatf("u%0d rd_e", k), 32'(re), 32'(ms[k][0].rd));
        check($sformatf("u%0d rd_m", k), 32'(rm), 32'(ms[k][1].rd));
        check($sformatf("u%0d rd_w", k), 32'(rw), 32'(ms[k][2].rd));
        check($sformatf("u%0d stall_f", k), 32'(sf), 32'(exp_sf));
        check($sformatf("u%0d stall_d", k), 32'(sd), 32'(exp_sf));
        check($sformatf("u%0d flush_d", k), 32'(fd), 32'(~hold & pc_src));
        check($sformatf("u%0d forward_a_e", k), 32'(fa), 32'(ref_fwd(k, ms[k][0].rs1)));
        check($sformatf("u%0d forward_b_e", k), 32'(fb), 32'(ref_fwd(k, ms[k][0].rs2)));
    endtask

    // Single compare process: both units against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_dut(0, bus0.ctrl_d, bus0.ctrl_e, bus0.ctrl_m, bus0.ctrl_w,
                      bus0.rd_e, bus0.rd_m, bus0.rd_w, bus0.stall_f, bus0.stall_d,
                      bus0.flush_d, bus0.forward_a_e, bus0.forward_b_e, bus0.illegal_d);
            check_dut(1, bus1.ctrl_d, bus1.ctrl_e, bus1.ctrl_m, bus1.ctrl_w,
                      bus1.rd_e, bus1.rd_m, bus1.rd_w, bus1.stall_f, bus1.stall_d,
                      bus1.flush_d, bus1.forward_a_e, bus1.forward_b_e, bus1.illegal_d);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, op};
    endfunction

    // Present Decode inputs, then wait until the compare process has run.
    task automatic put(input logic [31:0] ins, input logic pc, input logic hd);
        instr  = ins;
        pc_src = pc;
        hold   = hd;
        @(negedge clk);
        #1;
    endtask

    // Predict the next stage contents, take the rising edge, commit.
    task automatic clk_edge();
        slot_t nx [2][3];
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 3; s++) nx[k][s] = ms[k][s];
            if (rst) begin
                for (int s = 0; s < 3; s++) nx[k][s] = '0;
            end else if (!hold) begin
                nx[k][2] = ms[k][1];
                nx[k][1] = ms[k][0];
                if (ref_hazard(k) || pc_src) begin
                    nx[k][0] = '0;
                end else begin
                    nx[k][0].c   = ref_decode(instr[6:0]);
                    nx[k][0].rd  = instr[11:7];
                    nx[k][0].rs1 = instr[19:15];
                    nx[k][0].rs2 = instr[24:20];
                end
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 3; s++) ms[k][s] = nx[k][s];
        #1;
    endtask

    task automatic step(input logic [31:0] ins, input logic pc, input logic hd);
        put(ins, pc, hd);
        clk_edge();
    endtask

    logic [31:0] nop;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        nop    = enc(T_I, 5'd0, 5'd0, 5'd0);
        rst    = 1'b1;
        instr  = 32'h0;
        pc_src = 1'b0;
        hold   = 1'b0;
        chk_en = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 3; s++) ms[k][s] = '0;

        // Reset state with instr_d = 0: only illegal_d is high.
        put(32'h0, 1'b0, 1'b0);
        clk_edge();
        chk_en = 1'b1;
        put(32'h0, 1'b0, 1'b0);
        check("reset ctrl_e", 32'(bus0.ctrl_e), 32'h0);
        check("reset ctrl_d", 32'(bus0.ctrl_d), 32'h0);
        check("reset illegal_d", 32'(bus0.illegal_d), 32'h1);
        check("reset stall_f", 32'(bus0.stall_f), 32'h0);
        clk_edge();
        rst = 1'b0;

        // lw x5,0(x1) ; add x6,x5,x2 : one stall, then WB forward.
        put(enc(T_LOAD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0);
        check("lu first stall_f", 32'(bus0.stall_f), 32'h0);
        clk_edge();
        put(enc(T_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b0);
        check("lu stall_f", 32'(bus0.stall_f), 32'h1);
        check("lu stall_d", 32'(bus0.stall_d), 32'h1);
        clk_edge();
        put(enc(T_R, 5'd6, 5'd5, 5'd2), 1'b0, 1'b0);
        check("lu bubble ctrl_e", 32'(bus0.ctrl_e), 32'h0);
        check("lu released stall_f", 32'(bus0.stall_f), 32'h0);
        clk_edge();
        put(nop, 1'b0, 1'b0);
        check("lu forward_a_e", 32'(bus0.forward_a_e), 32'h1);
        clk_edge();

        // add x3,x1,x2 ; sub x4,x3,x3 : MEM forward on both sources.
        step(enc(T_R, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
        put(enc(T_R, 5'd4, 5'd3, 5'd3), 1'b0, 1'b0);
        check("raw no stall", 32'(bus0.stall_f), 32'h0);
        clk_edge();
        put(nop, 1'b0, 1'b0);
        check("raw forward_a_e", 32'(bus0.forward_a_e), 32'h2);
        check("raw forward_b_e", 32'(bus0.forward_b_e), 32'h2);
        clk_edge();

        // x0 is never a hazard nor forwarded.
        step(enc(T_R, 5'd0, 5'd1, 5'd2), 1'b0, 1'b0);
        put(enc(T_R, 5'd4, 5'd0, 5'd0), 1'b0, 1'b0);
        check("x0 stall fwd", 32'(bus0.stall_f), 32'h0);
        check("x0 stall nofwd", 32'(bus1.stall_f), 32'h0);
        clk_edge();
        put(nop, 1'b0, 1'b0);
        check("x0 forward_a_e", 32'(bus0.forward_a_e), 32'h0);
        check("x0 forward_b_e", 32'(bus0.forward_b_e), 32'h0);
        clk_edge();

        // Stall-only unit: add x3,x1,x2 ; or x4,x3,x1 -> two stall cycles.
        for (int i = 0; i < 3; i++) step(nop, 1'b0, 1'b0);
        step(enc(T_R, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
        put(enc(T_R, 5'd4, 5'd3, 5'd1), 1'b0, 1'b0);
        check("nofwd stall 1", 32'(bus1.stall_f), 32'h1);
        check("fwd no stall", 32'(bus0.stall_f), 32'h0);
        clk_edge();
        put(enc(T_R, 5'd4, 5'd3, 5'd1), 1'b0, 1'b0);
        check("nofwd stall 2", 32'(bus1.stall_f), 32'h1);
        check("fwd unit forward_a_e", 32'(bus0.forward_a_e), 32'h2);
        check("nofwd forward_a_e", 32'(bus1.forward_a_e), 32'h0);
        clk_edge();
        put(enc(T_R, 5'd4, 5'd3, 5'd1), 1'b0, 1'b0);
        check("nofwd W no stall", 32'(bus1.stall_f), 32'h0);
        clk_edge();

        // Load-use hazard together with a taken branch: flush wins.
        for (int i = 0; i < 3; i++) step(nop, 1'b0, 1'b0);
        step(enc(T_LOAD, 5'd5, 5'd1, 5'd0), 1'b0, 1'b0);
        put(enc(T_R, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0);
        check("br flush_d", 32'(bus0.flush_d), 32'h1);
        check("br stall_f", 32'(bus0.stall_f), 32'h0);
        check("br stall_d", 32'(bus0.stall_d), 32'h0);
        clk_edge();
        put(nop, 1'b0, 1'b0);
        check("br bubble ctrl_e", 32'(bus0.ctrl_e), 32'h0);
        clk_edge();

        // hold for 3 cycles with a load in M; branch pending on the last one.
        for (int i = 0; i < 3; i++) step(nop, 1'b0, 1'b0);
        step(enc(T_LOAD, 5'd7, 5'd1, 5'd0), 1'b0, 1'b0);
        step(nop, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            put(nop, (i == 2), 1'b1);
            check("hold rd_m", 32'(bus0.rd_m), 32'd7);
            check("hold mem_read m", 32'(bus0.ctrl_m.mem_read), 32'h1);
            check("hold stall_f", 32'(bus0.stall_f), 32'h1);
            check("hold flush_d", 32'(bus0.flush_d), 32'h0);
            clk_edge();
        end
        put(nop, 1'b1, 1'b0);
        check("post-hold flush_d", 32'(bus0.flush_d), 32'h1);
        check("post-hold rd_m", 32'(bus0.rd_m), 32'd7);
        clk_edge();
        put(nop, 1'b0, 1'b0);
        check("load in W rd_w", 32'(bus0.rd_w), 32'd7);
        check("load in W mem_read", 32'(bus0.ctrl_w.mem_read), 32'h1);
        check("post-hold bubble", 32'(bus0.ctrl_e), 32'h0);
        clk_edge();

        // Decode table pins and illegal opcodes.
        put(enc(T_LUI, 5'd9, 5'd0, 5'd0), 1'b0, 1'b0);
        check("lui ctrl_d", 32'(bus0.ctrl_d), 32'b10010001110000);
        clk_edge();
        put(enc(T_JAL, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0);
        check("jal ctrl_d", 32'(bus0.ctrl_d), 32'b11001111010011);
        clk_edge();
        step(enc(T_JALR, 5'd1, 5'd9, 5'd0), 1'b0, 1'b0);
        step(enc(T_STORE, 5'd0, 5'd1, 5'd9), 1'b0, 1'b0);
        step(enc(T_B, 5'd0, 5'd1, 5'd2), 1'b0, 1'b0);
        put(32'h0, 1'b0, 1'b0);
        check("op0 illegal_d", 32'(bus0.illegal_d), 32'h1);
        check("op0 ctrl_d", 32'(bus0.ctrl_d), 32'h0);
        clk_edge();
        put(enc(7'b1111111, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0);
        check("op7f illegal_d", 32'(bus0.illegal_d), 32'h1);
        clk_edge();

        // Reset mid-stream, asserted together with hold.
        step(enc(T_R, 5'd3, 5'd1, 5'd2), 1'b0, 1'b0);
        step(enc(T_LOAD, 5'd5, 5'd3, 5'd0), 1'b0, 1'b0);
        rst = 1'b1;
        step(nop, 1'b0, 1'b1);
        rst = 1'b0;
        put(nop, 1'b0, 1'b0);
        check("rst ctrl_e", 32'(bus0.ctrl_e), 32'h0);
        check("rst ctrl_m", 32'(bus0.ctrl_m), 32'h0);
        check("rst ctrl_w", 32'(bus0.ctrl_w), 32'h0);
        check("rst rd_m", 32'(bus0.rd_m), 32'h0);
        check("rst nofwd ctrl_m", 32'(bus1.ctrl_m), 32'h0);
        clk_edge();
        step(nop, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Control and hazard unit for the five-stage pipelined RV32I core. Decodes the opcode in Decode and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use and RAW hazards, generates stall and flush, and drives the operand forwarding selects. It generalises the single-cycle main decoder: configurable register-address width, selectable forwarding or stall-only mode, and a global hold.

## Interface
Parameters:
- REG_AW, 5, register address width
- FWD_EN, 1, 1 = forwarding enabled; 0 = every RAW on an in-flight writer stalls
- HOLD_EN, 1, 1 = `hold` input honoured; 0 = `hold` ignored

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- instr_d  in  32  instruction in Decode
- pc_src_e  in  1  branch/jump taken, resolved in Execute
- hold  in  1  freeze all stages (memory wait)
- ctrl_d  out  ctrl_t  decoded bundle, combinational
- ctrl_e, ctrl_m, ctrl_w  out  ctrl_t  registered bundles per stage
- rd_e, rd_m, rd_w  out  REG_AW  destination register per stage
- stall_f, stall_d  out  1  hold PC and IF/ID
- flush_d  out  1  clear IF/ID
- forward_a_e, forward_b_e  out  2  00 = register file, 01 = WB result, 10 = MEM ALU result
- illegal_d  out  1  opcode in Decode not in the table

## Operation
- `ctrl_t` fields: `valid`, `branch[1:0]`, `imm_src[2:0]`, `alu_src`, `result_src[1:0]`, `reg_write`, `mem_write`, `mem_read`, `alu_op[1:0]`.
- Decode table, opcode → alu_op/alu_src/result_src/reg_write/mem_write/imm_src/branch, plus mem_read:
  - R 0110011 → 10/0/01/1/0/000/00
  - B 1100011 → 01/0/00/0/0/010/01
  - I-ALU 0010011 → 00/1/01/1/0/000/00
  - Load 0000011 → 00/1/00/1/0/000/00, mem_read = 1
  - Store 0100011 → 00/1/00/0/1/001/00
  - JAL 1101111 → 11/1/10/1/0/011/10
  - LUI 0110111 → 00/0/11/1/0/100/00
  - JALR 1100111 → 00/0/10/1/0/000/11
  - Any other opcode → all zeros, valid = 0, illegal_d = 1
- For every opcode in the table, mem_read = 0 except Load.
- `valid` = 1 for all table opcodes.
- Sources: rs1_d = instr_d[19:15], rs2_d = instr_d[24:20], rd_d = instr_d[11:7], truncated or zero-extended to REG_AW.
- rs1 and rs2 are registered internally into Execute.
- Per-source use flags:
  - rs1 unused for JAL and LUI.
  - rs2 used only for R, B and Store.
- Register x0 never creates a hazard and is never forwarded.
- load_use = ctrl_e.valid & ctrl_e.mem_read & rd_e≠0 & (rd_e matches a used rs in Decode).
- FWD_EN = 0: a stall is also raised on any used-rs match with a valid reg_write in E or M. The register file writes first-half, so W needs no stall.
- Forwarding (FWD_EN = 1), per source in Execute:
  - 10 if ctrl_m.reg_write & rd_m≠0 & rd_m = rs_e
  - else 01 if ctrl_w.reg_write & rd_w≠0 & rd_w = rs_e
  - else 00
  - M has priority over W.
- FWD_EN = 0: forward outputs are constant 00.

## Timing
- ctrl_d, illegal_d, stall_f, stall_d, flush_d and forward selects are combinational.
- Stage bundles advance one stage per clock; latency from Decode to Writeback is 3 cycles.
- Stall: stall_f = stall_d = 1; ID/EX loads a bubble (all zeros); EX/MEM and MEM/WB advance.
- pc_src_e = 1:
  - flush_d = 1, ID/EX loads a bubble.
  - stall_f and stall_d are forced to 0, so the branch overrides a simultaneous stall.
- hold = 1 (HOLD_EN = 1):
  - All stage registers keep their value; stall_f = stall_d = 1; flush_d = 0.
  - hold has priority over pc_src_e and stall.
  - The flush is taken in the first cycle after hold drops while pc_src_e is still high.
- Reset:
  - All stage registers clear to zero (valid = 0); rd_* = 0; rs_e = 0.
  - With instr_d = 0 during reset, every output is 0 except illegal_d = 1.
  - A reset during a stall or hold clears the state in the same edge.

## Structure
- Package `control_pkg` holds:
  - `ctrl_t`
  - opcode localparams (OP_R, OP_B, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_LUI, OP_JALR)
  - forward-select localparams (FWD_RF, FWD_WB, FWD_MEM)
- One sub-module, `control_decode`: combinational opcode → ctrl_t, plus illegal flag and rs-use flags.
- Stage registers, hazard logic and forwarding live in the top module.

## Test plan
- `lw x5,0(x1)` then `add x6,x5,x2`:
  - one cycle of stall_f = stall_d = 1 with a bubble in E
  - next cycle forward_a_e = 01
- `add x3,x1,x2` then `sub x4,x3,x3`:
  - no stall; forward_a_e = forward_b_e = 10
- `add x0,x1,x2` then `add x4,x0,x0`:
  - forward selects stay 00; no stall
- Load-use hazard and pc_src_e = 1 in the same cycle:
  - flush_d = 1, stall_f = 0, bubble in E
- hold = 1 for 3 cycles with a load in M:
  - all ctrl_e/m/w and rd_* are unchanged
  - the load reaches W one cycle after hold drops
- FWD_EN = 0: `add x3,x1,x2` then `or x4,x3,x1`:
  - 2 stall cycles; forward selects always 00
- Opcode 0000000:
  - illegal_d = 1, ctrl_d = 0
- rst asserted mid-stream:
  - all stage bundles are 0 after one edge
